rle_spi_fetch: RTL

- Upstream feeder for the RLE video decoder.
- Streams 16-bit run/colour words from an SPI flash using READ command 0x03, single lane, SCK = clk/2.
- Buffers the words in a small FIFO and presents them on a ready/pop interface.
- Maintains the word address, including the decoder's clear, save and load requests used for frame restart and looping.

---
 rtl/rle_pkg.sv | 10 +
 rtl/rle_word_fifo.sv | 49 ++++
 rtl/rle_spi_fetch.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared constants and types for the RLE decoder's SPI flash front end.
package rle_pkg;

  localparam logic [7:0]  SPI_CMD_READ = 8'h03;
  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned WORD_W       = 16;

  typedef enum logic [1:0] {IDLE, CMD, DATA, PAUSE} fetch_state_t;

endpackage

// File: rtl/rle_word_fifo.sv
// Small synchronous word FIFO with flush; read data reads as zero while empty.
module rle_word_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             push_en;
  logic             pop_en;

  // Extra pointer bit tells a full FIFO apart from an empty one.
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + (AW+1)'(1);
      if (pop_en)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rle_spi_fetch.sv
// Streams 16-bit words from SPI flash (READ 0x03, SCK = clk/2) into a FIFO for the RLE
// decoder, and tracks the consumer's word address with save/load/clear support.
module rle_spi_fetch
  import rle_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] START_ADDR = 24'h000000,
  parameter int unsigned       CS_GAP     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              read_next,
  input  logic              stop_data,
  output logic              data_ready,
  output logic [WORD_W-1:0] data,
  input  logic              save_addr,
  input  logic              load_addr,
  input  logic              clear_addr,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned     GapW    = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'(CS_GAP);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] saved_q, saved_d;
  logic [ADDR_W-1:0] addr_popped;
  logic [31:0]       shift_q, shift_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              cs_n_q, cs_n_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;

  assign data_ready = !fifo_empty;
  assign pop        = read_next && data_ready;
  assign spi_cs_n   = cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;

  // A clear at the start address without a pop leaves the stream alone.
  assign flush = stop_data || load_addr || (clear_addr && ((addr_q != START_ADDR) || pop));

  assign addr_popped = pop ? addr_q + ADDR_W'(2) : addr_q;

  always_comb begin
    addr_d  = addr_popped;
    saved_d = save_addr ? addr_popped : saved_q;
    if (load_addr)  addr_d = saved_q;
    if (clear_addr) addr_d = START_ADDR;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    push      = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      gap_d     = GapInit;
      cs_n_d    = 1'b1;
      sck_d     = 1'b0;
      mosi_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GapW'(1);
          end else begin
            state_d   = CMD;
            shift_d   = {SPI_CMD_READ, addr_q};
            mosi_d    = shift_d[31];
            bit_cnt_d = '0;
            cs_n_d    = 1'b0;
          end
        end
        CMD: begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d     = 1'b0;
            shift_d   = {shift_q[30:0], 1'b0};
            mosi_d    = shift_q[30];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              state_d   = DATA;
              bit_cnt_d = '0;
              mosi_d    = 1'b0;
            end
          end
        end
        DATA: begin
          if (!sck_q) begin
            // Only stall on a word boundary, before its first rising edge.
            if (bit_cnt_q == 5'd0 && fifo_full) begin
              state_d = PAUSE;
            end else begin
              sck_d   = 1'b1;
              shift_d = {shift_q[30:0], spi_miso};
            end
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              push      = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
        PAUSE: begin
          if (!fifo_full) begin
            state_d = DATA;
            sck_d   = 1'b1;
            shift_d = {shift_q[30:0], spi_miso};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= START_ADDR;
      saved_q   <= START_ADDR;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= GapInit;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      saved_q   <= saved_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  rle_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .wdata(shift_q[WORD_W-1:0]),
    .pop  (pop),
    .flush(flush),
    .rdata(data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule
